// File: rtl/calc_sequencer.sv
// Key-driven sequencer for a BCD calculator: collects two operands and an operator,
// launches an external ALU, and tracks the result, errors and a pending clear.
module calc_sequencer #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned ALU_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid_i,
    input  logic [3:0]            key_code_i,
    output logic                  alu_start_o,
    output logic                  alu_op_o,
    output logic [4*DIGITS-1:0]   alu_a_o,
    output logic [4*DIGITS-1:0]   alu_b_o,
    input  logic                  alu_done_i,
    input  logic [4*DIGITS-1:0]   alu_result_i,
    input  logic                  alu_ovf_i,
    output logic [4*DIGITS-1:0]   disp_value_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [2:0]            state_o
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);
    localparam int unsigned WdW  = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StEnterA  = 3'd0,
        StEnterB  = 3'd1,
        StExec    = 3'd2,
        StWaitAlu = 3'd3,
        StShow    = 3'd4,
        StError   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            op_q, op_d, pend_q, pend_d;

    logic is_digit, is_op, is_eq, is_clr, do_clear, timeout;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        pend_d   = pend_q;
        wd_d     = wd_q;
        do_clear = 1'b0;
        is_digit = key_valid_i && (key_code_i <= 4'd9);
        is_op    = key_valid_i && (key_code_i == 4'hA || key_code_i == 4'hB);
        is_eq    = key_valid_i && (key_code_i == 4'hC);
        is_clr   = key_valid_i && (key_code_i == 4'hD);
        timeout  = (wd_q == WdW'(ALU_TIMEOUT - 1));

        case (state_q)
            StEnterA, StEnterB: begin
                if (is_clr) begin
                    do_clear = 1'b1;
                end else if (is_digit) begin
                    if (cnt_q < CntW'(DIGITS)) begin
                        if (state_q == StEnterA) a_d = (a_q << 4) | W'(key_code_i);
                        else                     b_d = (b_q << 4) | W'(key_code_i);
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (is_op) begin
                    if (state_q == StEnterA) begin
                        op_d    = key_code_i[0];
                        b_d     = '0;
                        cnt_d   = '0;
                        state_d = StEnterB;
                    end else if (cnt_q == '0) begin
                        op_d = key_code_i[0];
                    end
                end else if (is_eq && state_q == StEnterB) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_clr) pend_d = 1'b1;
                wd_d    = '0;
                state_d = StWaitAlu;
            end
            StWaitAlu: begin
                // A clear arriving with alu_done still wins over the result.
                if (alu_done_i || timeout) begin
                    if (pend_q || is_clr) begin
                        do_clear = 1'b1;
                    end else if (alu_done_i && !alu_ovf_i) begin
                        r_d     = alu_result_i;
                        state_d = StShow;
                    end else begin
                        state_d = StError;
                    end
                end else begin
                    wd_d = wd_q + WdW'(1);
                    if (is_clr) pend_d = 1'b1;
                end
            end
            StShow: begin
                if (is_clr) begin
                    do_clear = 1'b1;
                end else if (is_digit) begin
                    a_d     = W'(key_code_i);
                    cnt_d   = CntW'(1);
                    state_d = StEnterA;
                end else if (is_op) begin
                    a_d     = r_q;
                    op_d    = key_code_i[0];
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = StEnterB;
                end
            end
            StError: begin
                if (is_clr) do_clear = 1'b1;
            end
            default: state_d = StEnterA;
        endcase

        if (do_clear) begin
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_d   = '0;
            op_d    = 1'b0;
            pend_d  = 1'b0;
            wd_d    = '0;
            state_d = StEnterA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEnterA;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            pend_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs are forced low combinationally so they read zero during the reset cycle itself.
    always_comb begin
        alu_start_o  = 1'b0;
        alu_op_o     = 1'b0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        disp_value_o = '0;
        err_o        = 1'b0;
        busy_o       = 1'b0;
        state_o      = 3'd0;
        if (!reset) begin
            alu_start_o = (state_q == StExec);
            alu_op_o    = op_q;
            alu_a_o     = a_q;
            alu_b_o     = b_q;
            err_o       = (state_q == StError);
            busy_o      = (state_q == StExec) || (state_q == StWaitAlu);
            state_o     = state_q;
            case (state_q)
                StEnterA:          disp_value_o = a_q;
                StEnterB:          disp_value_o = (cnt_q != '0) ? b_q : a_q;
                StExec, StWaitAlu: disp_value_o = b_q;
                StShow:            disp_value_o = r_q;
                default:           disp_value_o = '0;
            endcase
        end
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: DIGITS, default 4, maximum BCD digits per operand; operand width W = 4*DIGITS.
REQ-002 Parameter: ALU_TIMEOUT, default 255, maximum cycles to wait for alu_done.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  one-cycle pulse; key_code valid this cycle.
REQ-006 key_code  input  4  0x0-0x9 digit; 0xA add; 0xB subtract; 0xC equals; 0xD clear; 0xE/0xF no-op.
REQ-007 alu_start  output  1  one-cycle pulse launching the ALU.
REQ-008 alu_op  output  1  0 add, 1 subtract; stable from alu_start until alu_done.
REQ-009 alu_a, alu_b  output  W  BCD operands; stable from alu_start until alu_done.
REQ-010 alu_done  input  1  one-cycle pulse; alu_result and alu_ovf valid this cycle.
REQ-011 alu_result  input  W  BCD result.
REQ-012 alu_ovf  input  1  result overflow or negative.
REQ-013 disp_value  output  W  BCD value to display.
REQ-014 err  output  1  high while in ERROR.
REQ-015 busy  output  1  high in EXEC and WAIT_ALU.
REQ-016 state  output  3  current state encoding, for debug.

Function
REQ-017 States, with encoding: ENTER_A=0, ENTER_B=1, EXEC=2, WAIT_ALU=3, SHOW=4, ERROR=5; unused codes go to ENTER_A on the next cycle.
REQ-018 Digit in ENTER_A/ENTER_B: if count<DIGITS, operand <= {operand[W-5:0], digit} and count++; otherwise the key is ignored.
REQ-019 Add/sub in ENTER_A: latch op, clear B and count, go to ENTER_B.
REQ-020 Add/sub in ENTER_B: if count==0, replace op; otherwise ignore.
REQ-021 Equals in ENTER_B: go to EXEC; equals in ENTER_A or SHOW is ignored.
REQ-022 EXEC lasts exactly one cycle: alu_start=1, then go to WAIT_ALU.
REQ-023 WAIT_ALU, alu_done with alu_ovf=0: latch result into R, go to SHOW.
REQ-024 WAIT_ALU, alu_done with alu_ovf=1: go to ERROR.
REQ-025 Watchdog counts cycles in WAIT_ALU; reaching ALU_TIMEOUT without alu_done goes to ERROR.
REQ-026 SHOW, digit key: A <= digit, count=1, go to ENTER_A.
REQ-027 SHOW, add/sub key: A <= R (chaining), latch op, clear B, go to ENTER_B.
REQ-028 Clear in any state except EXEC/WAIT_ALU: A, B, R, count, op <= 0; go to ENTER_A on the next cycle.
REQ-029 Clear in EXEC/WAIT_ALU sets clear_pending.
REQ-030 On alu_done or timeout with clear_pending set: discard the result, perform the clear, go to ENTER_A (not ERROR).
REQ-031 All non-clear keys in EXEC/WAIT_ALU are ignored.
REQ-032 In ERROR, only clear is accepted; disp_value = 0.
REQ-033 disp_value: A in ENTER_A; B in ENTER_B if count>0, else A; A-B operands held in EXEC/WAIT_ALU, showing B; R in SHOW.
REQ-034 key_valid coinciding with alu_done: alu_done is processed and the key is ignored, except clear, which is handled per REQ-029/REQ-030.
REQ-035 No arithmetic is done in this block; operand width never grows beyond W.

Reset
REQ-036 On reset=1 at a clock edge, the block SHALL enter ENTER_A and zero A, B, R, count, op, clear_pending and the watchdog.
REQ-037 While reset is applied, all outputs SHALL be 0: alu_start, alu_op, alu_a, alu_b, disp_value, err, busy, and state=0.
REQ-038 Reset during WAIT_ALU SHALL abandon the operation, and a later alu_done SHALL be ignored in ENTER_A.

Verification
REQ-039 Keys 1,2,+,3,4,= then alu_done with result 0x0046, ovf=0 -> one alu_start pulse with a=0x0012, b=0x0034, op=0; disp_value=0x0046 in SHOW.
REQ-040 Keys 1,2,3,4,5 -> A=0x1234, fifth digit ignored.
REQ-041 Keys 9,-,+,2 -> op=0 (replaced), B=0x0002.
REQ-042 Keys 5,+,3,=, clear during WAIT_ALU, then alu_done -> state=ENTER_A, A=0, err=0.
REQ-043 Keys 1,+,1,= with no alu_done for ALU_TIMEOUT cycles -> ERROR, err=1; digit ignored; clear -> ENTER_A.
REQ-044 After SHOW with R=0x0046, keys -,6,= -> alu_a=0x0046, alu_b=0x0006, op=1.
